// File: rtl/sha256_msg_sched_pkg.sv
// Shared types and constants for the SHA-256 message schedule generator.
package sha256_msg_sched_pkg;

    localparam int unsigned SHA256_BLOCK_WORDS = 16;
    localparam int unsigned SHA256_SCHED_WORDS = 64;
    localparam int unsigned SCHED_T_W          = $clog2(SHA256_SCHED_WORDS);

    // Last word index sourced from the message port, and last index of a block.
    localparam logic [SCHED_T_W-1:0] SCHED_T_LOAD_LAST = 6'd15;
    localparam logic [SCHED_T_W-1:0] SCHED_T_LAST      = 6'd63;

    typedef enum logic [0:0] {
        SCHED_LOAD   = 1'b0,
        SCHED_EXPAND = 1'b1
    } sha2_sched_state_t;

    // 32-bit rotate right; the doubled word makes the wrap-around a plain shift.
    function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] dbl;
        dbl = {x, x} >> n;
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Message-in / schedule-out handshake bundle of the schedule generator.
interface sha256_msg_sched_if;

    logic        msg_valid_i;
    logic [31:0] msg_word_i;
    logic        msg_ready_o;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [31:0] w_word_o;
    logic [5:0]  w_idx_o;
    logic        w_last_o;

    // Schedule generator side.
    modport slave (
        input  msg_valid_i, msg_word_i, w_ready_i,
        output msg_ready_o, w_valid_o, w_word_o, w_idx_o, w_last_o
    );

    // Producer/consumer side.
    modport master (
        output msg_valid_i, msg_word_i, w_ready_i,
        input  msg_ready_o, w_valid_o, w_word_o, w_idx_o, w_last_o
    );

endinterface

// File: rtl/sha256_msg_sched_sigma.sv
// SHA-256 small sigma functions of one operand, purely combinational.
module sha256_sigma
    import sha256_msg_sched_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] sig0,
    output logic [31:0] sig1
);

    assign sig0 = rotr32(x, 5'd7)  ^ rotr32(x, 5'd18) ^ (x >> 5'd3);
    assign sig1 = rotr32(x, 5'd17) ^ rotr32(x, 5'd19) ^ (x >> 5'd10);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator: passes M[0..15] through, then expands
// W[16..63] from a 16-word circular buffer, one word per output-slot load.
module sha256_msg_sched
    import sha256_msg_sched_pkg::*;
#(
    parameter bit LOGIC_GATING = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    sha256_msg_sched_if.slave  bus,
    output logic               busy_o
);

    sha2_sched_state_t      r_state;
    sha2_sched_state_t      w_state_next;
    logic [SCHED_T_W-1:0]   r_t;
    logic [SCHED_T_W-1:0]   w_t_next;

    // Circular buffer: slot t[3:0] holds W[t-16] until it is overwritten by W[t].
    logic [31:0]            r_buf [SHA256_BLOCK_WORDS];

    logic                   r_out_valid;
    logic [31:0]            r_out_word;
    logic [SCHED_T_W-1:0]   r_out_idx;
    logic                   r_out_last;

    logic                   w_in_load;
    logic                   w_in_expand;
    logic                   w_slot_free;
    logic                   w_msg_hs;
    logic                   w_exp_fire;
    logic                   w_load;

    logic [3:0]             w_idx_m2;
    logic [3:0]             w_idx_m7;
    logic [3:0]             w_idx_m15;
    logic [3:0]             w_idx_m16;
    logic                   w_gate;
    logic [31:0]            w_op_m2;
    logic [31:0]            w_op_m7;
    logic [31:0]            w_op_m15;
    logic [31:0]            w_op_m16;
    logic [31:0]            w_sig1_m2;
    logic [31:0]            w_sig0_m15;
    logic [31:0]            w_unused_sig0_m2;
    logic [31:0]            w_unused_sig1_m15;
    logic [31:0]            w_sum;
    logic [31:0]            w_new_word;

    // Handshake qualification: a load happens whenever the output slot frees up
    // and a word is available (from the port in LOAD, from the datapath in EXPAND).
    always_comb begin
        w_in_load   = (r_state == SCHED_LOAD);
        w_in_expand = (r_state == SCHED_EXPAND);
        w_slot_free = !r_out_valid || bus.w_ready_i;
        w_msg_hs    = w_in_load && w_slot_free && bus.msg_valid_i;
        w_exp_fire  = w_in_expand && w_slot_free;
        if (flush_i) begin
            w_load = 1'b0;
        end else begin
            w_load = w_msg_hs || w_exp_fire;
        end
    end

    // A flush cancels any handshake, so the port must not advertise acceptance.
    assign bus.msg_ready_o = w_in_load && w_slot_free && !flush_i;

    // Operand read indices relative to t; 4-bit arithmetic gives the modulo-16 wrap.
    assign w_idx_m2  = r_t[3:0] - 4'd2;
    assign w_idx_m7  = r_t[3:0] - 4'd7;
    assign w_idx_m15 = r_t[3:0] - 4'd15;
    assign w_idx_m16 = r_t[3:0];

    // Operand selection; with gating, the sigma/adder inputs are held at zero
    // outside EXPAND so the datapath does not toggle while words stream in.
    always_comb begin
        w_gate = !LOGIC_GATING || w_in_expand;
        if (w_gate) begin
            w_op_m2  = r_buf[w_idx_m2];
            w_op_m7  = r_buf[w_idx_m7];
            w_op_m15 = r_buf[w_idx_m15];
            w_op_m16 = r_buf[w_idx_m16];
        end else begin
            w_op_m2  = 32'd0;
            w_op_m7  = 32'd0;
            w_op_m15 = 32'd0;
            w_op_m16 = 32'd0;
        end
    end

    sha256_sigma u_sigma_m2 (
        .x    (w_op_m2),
        .sig0 (w_unused_sig0_m2),
        .sig1 (w_sig1_m2)
    );

    sha256_sigma u_sigma_m15 (
        .x    (w_op_m15),
        .sig0 (w_sig0_m15),
        .sig1 (w_unused_sig1_m15)
    );

    // W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16], modulo 2^32.
    assign w_sum = w_sig1_m2 + w_op_m7 + w_sig0_m15 + w_op_m16;

    // Word entering the output register and buffer this cycle.
    always_comb begin
        if (w_in_load) begin
            w_new_word = bus.msg_word_i;
        end else begin
            w_new_word = w_sum;
        end
    end

    // Next-state logic: t advances per load; LOAD->EXPAND at 15->16, EXPAND->LOAD at 63->0.
    always_comb begin
        w_state_next = r_state;
        w_t_next     = r_t;
        if (flush_i) begin
            w_state_next = SCHED_LOAD;
            w_t_next     = 6'd0;
        end else if (w_load) begin
            w_t_next = r_t + 6'd1;
            case (r_state)
                SCHED_LOAD: begin
                    if (r_t == SCHED_T_LOAD_LAST) begin
                        w_state_next = SCHED_EXPAND;
                    end else begin
                        w_state_next = SCHED_LOAD;
                    end
                end
                SCHED_EXPAND: begin
                    if (r_t == SCHED_T_LAST) begin
                        w_state_next = SCHED_LOAD;
                    end else begin
                        w_state_next = SCHED_EXPAND;
                    end
                end
                default: begin
                    w_state_next = SCHED_LOAD;
                end
            endcase
        end else begin
            w_state_next = r_state;
            w_t_next     = r_t;
        end
    end

    // State and word counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SCHED_LOAD;
            r_t     <= 6'd0;
        end else begin
            r_state <= w_state_next;
            r_t     <= w_t_next;
        end
    end

    // Single output register: load on a new word, drain on consumer acceptance,
    // otherwise hold so data stays stable while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_word  <= 32'd0;
            r_out_idx   <= 6'd0;
            r_out_last  <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
            r_out_word  <= 32'd0;
            r_out_idx   <= 6'd0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_word  <= w_new_word;
            r_out_idx   <= r_t;
            r_out_last  <= (r_t == SCHED_T_LAST);
        end else if (bus.w_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    // Buffer write of the word just produced; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (w_load) begin
            r_buf[r_t[3:0]] <= w_new_word;
        end
    end

    assign bus.w_valid_o = r_out_valid;
    assign bus.w_word_o  = r_out_word;
    assign bus.w_idx_o   = r_out_idx;
    assign bus.w_last_o  = r_out_last;
    assign busy_o        = (r_t != 6'd0) || r_out_valid;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench: two instances (gated and ungated) driven in lockstep and
// compared against an array-based model of the FIPS 180-4 schedule recurrence.
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        msg_valid;
    logic [31:0] msg_word;
    logic        w_ready;
    logic        busy_g;
    logic        busy_u;

    always #5 clk = ~clk;

    sha256_msg_sched_if if_g ();
    sha256_msg_sched_if if_u ();

    assign if_g.msg_valid_i = msg_valid;
    assign if_g.msg_word_i  = msg_word;
    assign if_g.w_ready_i   = w_ready;
    assign if_u.msg_valid_i = msg_valid;
    assign if_u.msg_word_i  = msg_word;
    assign if_u.w_ready_i   = w_ready;

    sha256_msg_sched #(.LOGIC_GATING(1'b1)) dut_g (
        .clk_i (clk), .rst_ni (rst_n), .flush_i (flush), .bus (if_g.slave), .busy_o (busy_g)
    );

    sha256_msg_sched #(.LOGIC_GATING(1'b0)) dut_u (
        .clk_i (clk), .rst_ni (rst_n), .flush_i (flush), .bus (if_u.slave), .busy_o (busy_u)
    );

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sch_t [64];
    typedef struct { logic [31:0] word; logic [5:0] idx; } exp_t;
    typedef struct { int sel; int idx; logic [31:0] exp; } vec_t;

    logic [31:0] msg_q [$];
    exp_t        exp_q [$];
    logic [31:0] cap_g [64];
    logic [31:0] cap_u [64];
    vec_t        vecs  [8];
    int          errors = 0;
    int          checks = 0;
    int          max_streak;
    blk_t        abc_blk;
    blk_t        ones_blk;
    blk_t        rnd_blk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Straight recurrence over a full 64-entry array.
    function automatic void model(input blk_t m, output sch_t w);
        logic [31:0] s0;
        logic [31:0] s1;
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic queue_block(input blk_t m);
        sch_t w;
        model(m, w);
        for (int t = 0; t < 16; t++) msg_q.push_back(m[t]);
        for (int t = 0; t < 64; t++) exp_q.push_back('{word: w[t], idx: 6'(t)});
    endtask

    // Cycle loop: decide handshakes at the negedge, change inputs just after posedge.
    task automatic run_stream(input int ready_pct, input int valid_pct, input int stop_idx);
        bit          prev_stall = 1'b0;
        logic [31:0] pw = 32'd0;
        logic [5:0]  pi = 6'd0;
        logic        pl = 1'b0;
        int          streak = 0;
        exp_t        e;
        max_streak = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_valid", 32'(if_g.w_valid_o), 32'd1);
                check("hold_word", if_g.w_word_o, pw);
                check("hold_idx", 32'(if_g.w_idx_o), 32'(pi));
                check("hold_last", 32'(if_g.w_last_o), 32'(pl));
            end
            if (if_g.w_valid_o) streak++;
            else streak = 0;
            if (streak > max_streak) max_streak = streak;
            if (stop_idx >= 0 && if_g.w_valid_o && (32'(if_g.w_idx_o) == stop_idx)) return;
            if (if_g.w_valid_o && w_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got idx %0d, expected no word", if_g.w_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("word_g_W%0d", e.idx), if_g.w_word_o, e.word);
                    check($sformatf("idx_g_W%0d", e.idx), 32'(if_g.w_idx_o), 32'(e.idx));
                    check($sformatf("last_g_W%0d", e.idx), 32'(if_g.w_last_o), 32'(e.idx == 6'd63));
                    check($sformatf("valid_u_W%0d", e.idx), 32'(if_u.w_valid_o), 32'd1);
                    check($sformatf("word_u_W%0d", e.idx), if_u.w_word_o, e.word);
                    check($sformatf("last_u_W%0d", e.idx), 32'(if_u.w_last_o), 32'(e.idx == 6'd63));
                    cap_g[e.idx] = if_g.w_word_o;
                    cap_u[e.idx] = if_u.w_word_o;
                end
            end
            if (msg_valid && if_g.msg_ready_o && msg_q.size() > 0) void'(msg_q.pop_front());
            prev_stall = if_g.w_valid_o && !w_ready;
            pw = if_g.w_word_o;
            pi = if_g.w_idx_o;
            pl = if_g.w_last_o;
            if (exp_q.size() == 0 && msg_q.size() == 0) begin
                @(posedge clk);
                #1;
                msg_valid = 1'b0;
                w_ready   = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
            msg_valid = (msg_q.size() > 0) && ($urandom_range(99) < valid_pct);
            msg_word  = msg_valid ? msg_q[0] : $urandom;
            w_ready   = ($urandom_range(99) < ready_pct);
        end
        checks++;
        errors++;
        $display("FAIL timeout: %0d words outstanding, expected 0", exp_q.size());
    endtask

    task automatic check_table(input int sel);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].sel == sel) begin
                check($sformatf("tbl_g_W%0d", vecs[i].idx), cap_g[vecs[i].idx], vecs[i].exp);
                check($sformatf("tbl_u_W%0d", vecs[i].idx), cap_u[vecs[i].idx], vecs[i].exp);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(if_g.w_valid_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_g), 32'd0);
        check({tag, "_busy_u"}, 32'(busy_u), 32'd0);
        check({tag, "_msg_ready"}, 32'(if_g.msg_ready_o), 32'd1);
    endtask

    initial begin
        // NIST "abc" reference words; all-ones W16 = 0x003FFFFF + 0xFFFFFFFF
        // + 0x1FFFFFFF + 0xFFFFFFFF = 0x203FFFFC modulo 2^32.
        vecs[0] = '{0, 16, 32'h61626380};
        vecs[1] = '{0, 17, 32'h000F0000};
        vecs[2] = '{0, 18, 32'h7DA86405};
        vecs[3] = '{0, 19, 32'h600003C6};
        vecs[4] = '{0, 0,  32'h61626380};
        vecs[5] = '{0, 15, 32'h00000018};
        vecs[6] = '{1, 16, 32'h203FFFFC};
        vecs[7] = '{1, 0,  32'hFFFFFFFF};
        for (int i = 0; i < 16; i++) begin
            abc_blk[i]  = 32'd0;
            ones_blk[i] = 32'hFFFFFFFF;
        end
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;

        rst_n = 1'b0; flush = 1'b0; msg_valid = 1'b0; msg_word = 32'd0; w_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_word", if_g.w_word_o, 32'd0);
        check("rst_idx", 32'(if_g.w_idx_o), 32'd0);
        check("rst_last", 32'(if_g.w_last_o), 32'd0);
        check_idle("rst");

        // abc block, both sides always ready.
        queue_block(abc_blk);
        run_stream(100, 100, -1);
        check_table(0);
        @(negedge clk);
        check_idle("abc_drain");

        // All-ones block exercises adder wrap; gated and ungated must agree.
        queue_block(ones_blk);
        run_stream(100, 100, -1);
        check_table(1);

        // Random consumer and producer stalls on the abc block.
        queue_block(abc_blk);
        run_stream(50, 70, -1);
        check_table(0);

        // Two random blocks back to back: no bubble between them.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) rnd_blk[i] = $urandom;
            queue_block(rnd_blk);
        end
        run_stream(100, 100, -1);
        check("streak128", 32'(max_streak), 32'd128);

        // Flush mid-expansion, then a clean abc block.
        queue_block(abc_blk);
        run_stream(100, 100, 30);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_idle("flush");
        msg_q.delete();
        exp_q.delete();
        queue_block(abc_blk);
        run_stream(100, 100, -1);
        check_table(0);

        // Asynchronous reset mid-expansion clears outputs without waiting for a clock.
        queue_block(abc_blk);
        run_stream(100, 100, 40);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(if_g.w_valid_o), 32'd0);
        check("arst_word", if_g.w_word_o, 32'd0);
        check("arst_idx", 32'(if_g.w_idx_o), 32'd0);
        check("arst_busy", 32'(busy_g), 32'd0);
        check("arst_word_u", if_u.w_word_o, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("arst_rel");
        msg_q.delete();
        exp_q.delete();
        queue_block(abc_blk);
        run_stream(100, 100, -1);
        check_table(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
